// File: rtl/led_sequencer_pkg.sv
// Shared definitions for the LED sequencer.
//   mode_t     : display mode encoding, matching the 2-bit mode_sel input
//   dir_t      : breathe ramp direction
//   NUM_LEDS   : total LEDs driven (D1..D5)
//   CHASE_LEDS : LEDs in the red ring that take part in the chase
//   chase_onehot() : one-hot ring pattern for a chase step
package led_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ALL_ON  = 2'd1,
    MODE_CHASE   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam int NUM_LEDS   = 5;
  localparam int CHASE_LEDS = 4;

  // Step 0 lights D1 (bit 0), step 3 lights D4 (bit 3).
  function automatic logic [CHASE_LEDS-1:0] chase_onehot(input logic [1:0] step);
    logic [CHASE_LEDS-1:0] one;
    one = CHASE_LEDS'(1);
    return one << step;
  endfunction

endpackage

// File: rtl/led_sequencer_tick_div.sv
// tick_div: free-running clock divider.
//   clk  : system clock
//   rst  : synchronous active-high reset, counter to 0
//   clr  : synchronous restart, counter to 0 (same effect as rst)
//   tick : high for the one cycle in which the counter sits at DIV-1
// The counter runs 0..DIV-1 and wraps to 0 on the edge after tick.
module tick_div #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: drives the five iCEstick LEDs from one of four modes.
//   clk        : system clock (12 MHz on board)
//   rst        : synchronous active-high reset
//   mode_sel   : requested mode (0 OFF, 1 ALL_ON, 2 CHASE, 3 BREATHE)
//   mode_load  : one-cycle strobe, samples mode_sel on this edge
//   D1..D4     : red ring LEDs, 1 = lit
//   D5         : green centre LED
//   cycle_done : one-cycle pulse at the end of a chase or breathe cycle
//
// mode_load is a fire-and-forget strobe: there is no ready/backpressure,
// every cycle with mode_load high is accepted, and the accepted mode is
// visible on the LEDs one edge later. rst takes priority over mode_load.
//
// The LED outputs are registered from (mode, step, level, pwm_cnt), so
// they always trail the state registers by one edge.
module led_sequencer
  import led_sequencer_pkg::*;
#(
  parameter int STEP_DIV = 3000000,
  parameter int FADE_DIV = 23437,
  parameter int PWM_BITS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode_sel,
  input  logic       mode_load,
  output logic       D1,
  output logic       D2,
  output logic       D3,
  output logic       D4,
  output logic       D5,
  output logic       cycle_done
);

  localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;
  localparam logic [PWM_BITS-1:0] LEVEL_ONE = PWM_BITS'(1);

  logic step_tick;
  logic fade_tick;

  // Both dividers restart on a mode load so each mode starts its
  // pattern from a clean phase.
  tick_div #(.DIV(STEP_DIV)) u_step_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (mode_load),
    .tick (step_tick)
  );

  tick_div #(.DIV(FADE_DIV)) u_fade_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (mode_load),
    .tick (fade_tick)
  );

  // Mode state machine: state register + next-state logic.
  mode_t mode_q;
  mode_t mode_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_ALL_ON;
    end else begin
      mode_q <= mode_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    if (mode_load) begin
      mode_d = mode_t'(mode_sel);
    end
  end

  // Sequencer state: chase step, breathe level/direction, PWM counter.
  logic [1:0]          step_q, step_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  dir_t                dir_q, dir_d;
  logic [PWM_BITS-1:0] pwm_q;
  logic                done_d;

  always_comb begin
    step_d  = step_q;
    level_d = level_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    if (mode_load) begin
      // A load discards any tick arriving on the same edge.
      step_d  = 2'd0;
      level_d = '0;
      dir_d   = DIR_UP;
    end else begin
      if (mode_q == MODE_CHASE && step_tick) begin
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          done_d = 1'b1;
        end
      end
      if (mode_q == MODE_BREATHE && fade_tick) begin
        if (dir_q == DIR_UP) begin
          if (level_q == LEVEL_MAX) begin
            dir_d   = DIR_DOWN;
            level_d = LEVEL_MAX - LEVEL_ONE;
          end else begin
            level_d = level_q + LEVEL_ONE;
          end
        end else begin
          if (level_q == '0) begin
            // Turning at the bottom closes one breathe cycle.
            dir_d   = DIR_UP;
            level_d = LEVEL_ONE;
            done_d  = 1'b1;
          end else begin
            level_d = level_q - LEVEL_ONE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q     <= 2'd0;
      level_q    <= '0;
      dir_q      <= DIR_UP;
      pwm_q      <= '0;
      cycle_done <= 1'b0;
    end else begin
      step_q     <= step_d;
      level_q    <= level_d;
      dir_q      <= dir_d;
      pwm_q      <= mode_load ? '0 : pwm_q + LEVEL_ONE;
      cycle_done <= done_d;
    end
  end

  // Output register.
  logic [NUM_LEDS-1:0] leds_d;
  logic [NUM_LEDS-1:0] leds_q;

  always_comb begin
    leds_d = '0;
    unique case (mode_q)
      MODE_OFF:     leds_d = '0;
      MODE_ALL_ON:  leds_d = '1;
      MODE_CHASE:   leds_d = {1'b1, chase_onehot(step_q)};
      MODE_BREATHE: leds_d = {NUM_LEDS{pwm_q < level_q}};
      default:      leds_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      leds_q <= '0;
    end else begin
      leds_q <= leds_d;
    end
  end

  assign D1 = leds_q[0];
  assign D2 = leds_q[1];
  assign D3 = leds_q[2];
  assign D4 = leds_q[3];
  assign D5 = leds_q[4];

endmodule

// File: tb/tb_led_sequencer.sv
module tb_led_sequencer;

  // Clock / reset
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode_sel = 2'd0;
  logic       mode_load = 1'b0;
  logic       D1, D2, D3, D4, D5;
  logic       cycle_done;

  always #5 clk = ~clk;

  led_sequencer #(
    .STEP_DIV (4),
    .FADE_DIV (2),
    .PWM_BITS (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode_sel   (mode_sel),
    .mode_load  (mode_load),
    .D1         (D1),
    .D2         (D2),
    .D3         (D3),
    .D4         (D4),
    .D5         (D5),
    .cycle_done (cycle_done)
  );

  int total = 0;
  int bad   = 0;

  logic [4:0] leds;
  assign leds = {D5, D4, D3, D2, D1};

  // Driver tasks: everything happens 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mode(input logic [1:0] m);
    mode_sel  = m;
    mode_load = 1'b1;
    tick();
    mode_load = 1'b0;
  endtask

  // Breathe level after edge k+m, where k is the load edge (FADE_DIV=2, MAX=7).
  function automatic int lvl_at(input int m);
    if (m < 16)      return m / 2;
    else if (m < 30) return 6 - (m - 16) / 2;
    else             return 1 + (m - 30) / 2;
  endfunction

  function automatic logic [4:0] chase_exp(input int idx);
    logic [4:0] one;
    one = 5'b00001;
    return 5'b10000 | (one << (idx % 4));
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (leds !== 5'b00000 || cycle_done !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold i=%0d got leds=%b cd=%b want leds=00000 cd=0", i, leds, cycle_done);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (leds !== 5'b11111 || cycle_done !== 1'b0) begin
        bad++;
        $display("FAIL reset_release i=%0d got leds=%b cd=%b want leds=11111 cd=0", i, leds, cycle_done);
      end
    end
  endtask

  task automatic test_chase();
    logic [4:0] exp_leds;
    logic       exp_cd;
    load_mode(2'd2);
    for (int j = 1; j <= 20; j++) begin
      tick();
      exp_leds = chase_exp((j - 1) / 4);
      exp_cd   = (j == 16);
      total++;
      if (leds !== exp_leds || cycle_done !== exp_cd) begin
        bad++;
        $display("FAIL chase j=%0d got leds=%b cd=%b want leds=%b cd=%b", j, leds, cycle_done, exp_leds, exp_cd);
      end
    end
  endtask

  task automatic test_chase_reload();
    logic [4:0] exp_leds;
    load_mode(2'd2);
    for (int j = 1; j <= 11; j++) tick();
    // step = 2 and the step divider is on its terminal count here
    load_mode(2'd2);
    total++;
    if (leds !== 5'b10100 || cycle_done !== 1'b0) begin
      bad++;
      $display("FAIL reload_edge got leds=%b cd=%b want leds=10100 cd=0", leds, cycle_done);
    end
    for (int j = 1; j <= 8; j++) begin
      tick();
      exp_leds = chase_exp((j - 1) / 4);
      total++;
      if (leds !== exp_leds || cycle_done !== 1'b0) begin
        bad++;
        $display("FAIL reload j=%0d got leds=%b cd=%b want leds=%b cd=0", j, leds, cycle_done, exp_leds);
      end
    end
  endtask

  task automatic test_breathe();
    logic [4:0] exp_leds;
    logic       exp_cd;
    int         lit_l0;
    int         lit_l7;
    int         m;
    lit_l0 = 0;
    lit_l7 = 0;
    load_mode(2'd3);
    for (int s = 1; s <= 32; s++) begin
      tick();
      m        = s - 1;
      exp_leds = ((m % 8) < lvl_at(m)) ? 5'b11111 : 5'b00000;
      exp_cd   = (s == 30);
      total++;
      if (leds !== exp_leds || cycle_done !== exp_cd) begin
        bad++;
        $display("FAIL breathe s=%0d level=%0d got leds=%b cd=%b want leds=%b cd=%b",
                 s, lvl_at(m), leds, cycle_done, exp_leds, exp_cd);
      end
      if (m < 8)              lit_l0 += (leds === 5'b11111) ? 1 : 0;
      if (m == 14 || m == 15) lit_l7 += (leds === 5'b11111) ? 1 : 0;
    end
    // Level 0,0,1,1,2,2,3,3 over pwm 0..7: lit only at pwm 2,4,5,6,7? -> pwm<lvl: m=3(3<1 no)...
    // Window m=0..7: lit where (m%8)<m/2 -> none, so 0 lit.
    total++;
    if (lit_l0 !== 0) begin
      bad++;
      $display("FAIL breathe_low_window got lit=%0d want lit=0", lit_l0);
    end
    // At level 7: pwm 6 lit, pwm 7 dark.
    total++;
    if (lit_l7 !== 1) begin
      bad++;
      $display("FAIL breathe_level7 got lit=%0d want lit=1", lit_l7);
    end
  endtask

  task automatic test_off_on();
    load_mode(2'd0);
    for (int j = 1; j <= 3; j++) begin
      tick();
      total++;
      if (leds !== 5'b00000 || cycle_done !== 1'b0) begin
        bad++;
        $display("FAIL off j=%0d got leds=%b cd=%b want leds=00000 cd=0", j, leds, cycle_done);
      end
    end
    load_mode(2'd1);
    for (int j = 1; j <= 3; j++) begin
      tick();
      total++;
      if (leds !== 5'b11111 || cycle_done !== 1'b0) begin
        bad++;
        $display("FAIL all_on j=%0d got leds=%b cd=%b want leds=11111 cd=0", j, leds, cycle_done);
      end
    end
  endtask

  task automatic test_reset_vs_load();
    load_mode(2'd3);
    for (int j = 1; j <= 10; j++) tick();
    // level is 5 here; reset and load collide on the next edge
    rst       = 1'b1;
    mode_sel  = 2'd3;
    mode_load = 1'b1;
    tick();
    total++;
    if (leds !== 5'b00000 || cycle_done !== 1'b0) begin
      bad++;
      $display("FAIL rst_load_edge got leds=%b cd=%b want leds=00000 cd=0", leds, cycle_done);
    end
    rst       = 1'b0;
    mode_load = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      tick();
      total++;
      if (leds !== 5'b11111 || cycle_done !== 1'b0) begin
        bad++;
        $display("FAIL rst_load_after j=%0d got leds=%b cd=%b want leds=11111 cd=0", j, leds, cycle_done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_chase();
    test_chase_reload();
    test_breathe();
    test_off_on();
    test_reset_vs_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
